rectifier_seq: RTL and testbench

//  Sequencer for the grid-side rectifier switch table. Debounces the raw grid

---
 rtl/rectifier_seq.sv | 193 +++++++++++++++++++
 tb/tb_rectifier_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rectifier_seq.sv
// Grid-side rectifier sequencer: sector debounce, PWM carrier, two-vector split,
// dead-window insertion around every vector change, and latched fault handling.
module rectifier_seq #(
    parameter int PERIOD = 1000,
    parameter int DEAD   = 20,
    parameter int DEB    = 8
) (
    input  logic        sysclk,
    input  logic        global_rst,
    input  logic        en,
    input  logic [2:0]  sector_raw,
    input  logic [15:0] duty,
    input  logic        fault_in,
    input  logic        flt_clr,
    output logic [15:0] grid_sector,
    output logic        grid_judge,
    output logic        SD,
    output logic        pwm_sync,
    output logic        fault,
    output logic        sector_err,
    output logic [1:0]  o_dbg_state
);
    localparam int CW = $clog2(PERIOD);
    localparam int DW = $clog2(DEB + 1);
    localparam int TW = $clog2(DEAD + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(PERIOD - 1);
    localparam logic [15:0]   DUTY_MAX = 16'(PERIOD);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB - 1);
    localparam logic [TW-1:0] DEAD_MAX = TW'(DEAD - 1);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_DEAD  = 2'd1,
        S_RUN   = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    logic [CW-1:0] r_cnt;
    logic          r_sync;
    logic [2:0]    r_prev;
    logic [DW-1:0] r_deb;
    logic [2:0]    r_sec_stable;
    logic          r_sec_err;
    logic [2:0]    r_sec_p;
    logic [15:0]   r_duty_p;

    logic [CW-1:0] w_cnt_nx;
    logic          w_sync_nx;
    logic          w_raw_ok;
    logic [DW-1:0] w_deb_nx;
    logic [15:0]   w_duty_lim;
    logic [2:0]    w_sec_nx;
    logic [15:0]   w_duty_nx;
    logic          w_judge_cmd;

    // Everything is computed for the upcoming count so registered outputs line up with r_cnt.
    assign w_cnt_nx    = (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
    assign w_sync_nx   = (w_cnt_nx == '0);
    assign w_raw_ok    = (sector_raw != 3'd0) && (sector_raw != 3'd7);
    assign w_duty_lim  = (duty > DUTY_MAX) ? DUTY_MAX : duty;
    assign w_sec_nx    = (w_sync_nx && (r_sec_stable != 3'd0)) ? r_sec_stable : r_sec_p;
    assign w_duty_nx   = w_sync_nx ? w_duty_lim : r_duty_p;
    assign w_judge_cmd = (17'(w_cnt_nx) < 17'(w_duty_nx));

    always_comb begin
        w_deb_nx = '0;
        if (w_raw_ok && (sector_raw == r_prev)) begin
            w_deb_nx = (r_deb == DEB_MAX) ? r_deb : r_deb + 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (global_rst) begin
            r_cnt        <= '0;
            r_sync       <= 1'b0;
            r_prev       <= 3'd0;
            r_deb        <= '0;
            r_sec_stable <= 3'd0;
            r_sec_err    <= 1'b0;
            r_sec_p      <= 3'd1;
            r_duty_p     <= '0;
        end else begin
            r_cnt     <= w_cnt_nx;
            r_sync    <= w_sync_nx;
            r_prev    <= sector_raw;
            r_deb     <= w_deb_nx;
            r_sec_err <= !w_raw_ok;
            if (w_raw_ok && (w_deb_nx == DEB_MAX)) begin
                r_sec_stable <= sector_raw;
            end
            r_sec_p  <= w_sec_nx;
            r_duty_p <= w_duty_nx;
        end
    end

    state_t        r_state, w_state_nx;
    logic [2:0]    r_sector, w_sector_nx;
    logic          r_judge, w_judge_nx;
    logic          r_sd, w_sd_nx;
    logic          r_fault, w_fault_nx;
    logic [TW-1:0] r_dcnt, w_dcnt_nx;
    logic          w_vec_chg;

    assign w_vec_chg = (w_sec_nx != r_sector) || (w_judge_cmd != r_judge);

    always_comb begin
        w_state_nx  = r_state;
        w_sector_nx = r_sector;
        w_judge_nx  = r_judge;
        w_sd_nx     = r_sd;
        w_fault_nx  = r_fault;
        w_dcnt_nx   = r_dcnt;
        if (fault_in) begin
            w_state_nx = S_FAULT;
            w_sd_nx    = 1'b0;
            w_fault_nx = 1'b1;
        end else begin
            case (r_state)
                S_OFF: begin
                    w_sd_nx = 1'b0;
                    if (w_sync_nx && en && (r_sec_stable != 3'd0)) begin
                        w_state_nx  = S_DEAD;
                        w_sector_nx = w_sec_nx;
                        w_judge_nx  = w_judge_cmd;
                        w_dcnt_nx   = '0;
                    end
                end
                S_DEAD: begin
                    w_sd_nx = 1'b0;
                    if (!en) begin
                        w_state_nx = S_OFF;
                    end else if (w_vec_chg) begin
                        w_sector_nx = w_sec_nx;
                        w_judge_nx  = w_judge_cmd;
                        w_dcnt_nx   = '0;
                    end else if (r_dcnt == DEAD_MAX) begin
                        w_state_nx = S_RUN;
                        w_sd_nx    = 1'b1;
                    end else begin
                        w_dcnt_nx = r_dcnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!en) begin
                        w_state_nx = S_OFF;
                        w_sd_nx    = 1'b0;
                    end else if (w_vec_chg) begin
                        w_state_nx  = S_DEAD;
                        w_sd_nx     = 1'b0;
                        w_sector_nx = w_sec_nx;
                        w_judge_nx  = w_judge_cmd;
                        w_dcnt_nx   = '0;
                    end
                end
                default: begin
                    w_sd_nx    = 1'b0;
                    w_fault_nx = 1'b1;
                    if (flt_clr) begin
                        w_state_nx = S_OFF;
                        w_fault_nx = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (global_rst) begin
            r_state  <= S_OFF;
            r_sector <= 3'd1;
            r_judge  <= 1'b0;
            r_sd     <= 1'b0;
            r_fault  <= 1'b0;
            r_dcnt   <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_sector <= w_sector_nx;
            r_judge  <= w_judge_nx;
            r_sd     <= w_sd_nx;
            r_fault  <= w_fault_nx;
            r_dcnt   <= w_dcnt_nx;
        end
    end

    assign grid_sector = {13'd0, r_sector};
    assign grid_judge  = r_judge;
    assign SD          = r_sd;
    assign pwm_sync    = r_sync;
    assign fault       = r_fault;
    assign sector_err  = r_sec_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rectifier_seq.sv
// Directed bench for rectifier_seq with PERIOD=100, DEAD=5, DEB=4; n counts
// clock edges since the last reset edge, so n % 100 is the carrier count.
module tb_rectifier_seq;
    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_DEAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    logic        sysclk = 1'b0;
    logic        global_rst;
    logic        en;
    logic [2:0]  sector_raw;
    logic [15:0] duty;
    logic        fault_in;
    logic        flt_clr;
    logic [15:0] grid_sector;
    logic        grid_judge;
    logic        SD;
    logic        pwm_sync;
    logic        fault;
    logic        sector_err;
    logic [1:0]  o_dbg_state;

    int n;
    int n_tests;
    int n_fail;
    bit mon_en;
    logic [31:0] exp_q[$];

    rectifier_seq #(.PERIOD(100), .DEAD(5), .DEB(4)) dut (
        .sysclk      (sysclk),
        .global_rst  (global_rst),
        .en          (en),
        .sector_raw  (sector_raw),
        .duty        (duty),
        .fault_in    (fault_in),
        .flt_clr     (flt_clr),
        .grid_sector (grid_sector),
        .grid_judge  (grid_judge),
        .SD          (SD),
        .pwm_sync    (pwm_sync),
        .fault       (fault),
        .sector_err  (sector_err),
        .o_dbg_state (o_dbg_state)
    );

    // clock
    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_tests++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (n=%0d)", tag, obs, want, n);
        end
    endtask

    task automatic tick;
        @(posedge sysclk);
        #1;
        n++;
    endtask

    task automatic run_to(input int target);
        while (n < target) tick();
    endtask

    // Ticks up to 'last', counting cycles with SD low, judge high and sector_err high.
    task automatic observe(input int last, output int sd_low, output int judge_hi, output int err_hi);
        sd_low = 0;
        judge_hi = 0;
        err_hi = 0;
        while (n < last) begin
            tick();
            if (SD == 1'b0) sd_low++;
            if (grid_judge == 1'b1) judge_hi++;
            if (sector_err == 1'b1) err_hi++;
        end
    endtask

    // scoreboard: every pwm_sync must occur exactly at the next expected edge count
    always @(negedge sysclk) begin
        if (mon_en && pwm_sync) begin
            if (exp_q.size() == 0) check("sync_extra", 32'd1, 32'd0);
            else check("sync_time", n, exp_q.pop_front());
        end
    end

    initial begin
        int sd_low, judge_hi, err_hi;
        n_tests = 0;
        n_fail = 0;
        mon_en = 1'b0;
        global_rst = 1'b1;
        en = 1'b0;
        sector_raw = 3'd3;
        duty = 16'd40;
        fault_in = 1'b0;
        flt_clr = 1'b0;
        for (int k = 1; k <= 11; k++) exp_q.push_back(32'(k * 100));

        repeat (3) tick();
        check("rst_sd", SD, 0);
        check("rst_sector", grid_sector, 1);
        check("rst_judge", grid_judge, 0);
        check("rst_sync", pwm_sync, 0);
        check("rst_fault", fault, 0);
        check("rst_err", sector_err, 0);
        check("rst_state", o_dbg_state, ST_OFF);
        global_rst = 1'b0;
        en = 1'b1;
        n = 0;
        mon_en = 1'b1;

        // startup
        run_to(99);
        check("pre_sync_sd", SD, 0);
        check("pre_sync_state", o_dbg_state, ST_OFF);
        run_to(100);
        check("first_sync", pwm_sync, 1);
        check("start_state", o_dbg_state, ST_DEAD);
        check("start_sector", grid_sector, 3);
        check("start_judge", grid_judge, 1);
        check("start_sd", SD, 0);
        run_to(104);
        check("dead_end_sd", SD, 0);
        run_to(105);
        check("sd_rise", SD, 1);
        check("run_state", o_dbg_state, ST_RUN);
        run_to(139);
        check("judge_hi_39", grid_judge, 1);
        run_to(140);
        check("mid_dead_sd", SD, 0);
        check("mid_judge", grid_judge, 0);
        run_to(145);
        check("mid_run_sd", SD, 1);
        check("mid_run_judge", grid_judge, 0);
        run_to(199);
        observe(299, sd_low, judge_hi, err_hi);
        check("period_sd_low", sd_low, 10);
        check("period_judge_hi", judge_hi, 40);

        // debounce: 3-cycle glitch rejected, then held change accepted
        sector_raw = 3'd4;
        repeat (3) tick();
        sector_raw = 3'd3;
        run_to(405);
        check("glitch_sector", grid_sector, 3);
        run_to(410);
        sector_raw = 3'd4;
        run_to(499);
        check("pre_new_sector", grid_sector, 3);
        run_to(500);
        check("new_sector", grid_sector, 4);
        check("new_sector_sd", SD, 0);
        run_to(505);
        check("new_sector_run", SD, 1);

        // invalid samples
        run_to(510);
        sector_raw = 3'd7;
        observe(520, sd_low, judge_hi, err_hi);
        check("err_pulses", err_hi, 10);
        sector_raw = 3'd4;
        observe(540, sd_low, judge_hi, err_hi);
        check("err_after", err_hi, 0);
        check("inv_sector", grid_sector, 4);

        // duty edges
        duty = 16'd0;
        run_to(599);
        observe(699, sd_low, judge_hi, err_hi);
        check("duty0_sd_low", sd_low, 0);
        check("duty0_judge_hi", judge_hi, 0);
        duty = 16'd150;
        run_to(700);
        check("duty150_judge", grid_judge, 1);
        check("duty150_dead", SD, 0);
        run_to(704);
        observe(899, sd_low, judge_hi, err_hi);
        check("duty150_sd_low", sd_low, 0);
        check("duty150_judge_hi", judge_hi, 195);
        run_to(900);
        check("wrap_no_drop", SD, 1);

        // fault latch and clear
        fault_in = 1'b1;
        tick();
        check("flt_sd", SD, 0);
        check("flt_flag", fault, 1);
        check("flt_state", o_dbg_state, ST_FAULT);
        flt_clr = 1'b1;
        tick();
        flt_clr = 1'b0;
        fault_in = 1'b0;
        tick();
        check("clr_ignored", fault, 1);
        check("clr_ign_state", o_dbg_state, ST_FAULT);
        run_to(905);
        check("flt_latched", fault, 1);
        flt_clr = 1'b1;
        tick();
        flt_clr = 1'b0;
        check("clr_fault", fault, 0);
        check("clr_state", o_dbg_state, ST_OFF);
        check("clr_sd", SD, 0);
        run_to(999);
        check("off_wait_sd", SD, 0);
        run_to(1000);
        check("restart_state", o_dbg_state, ST_DEAD);
        run_to(1005);
        check("restart_sd", SD, 1);

        // reset during DEAD
        duty = 16'd40;
        run_to(1142);
        check("pre_rst_state", o_dbg_state, ST_DEAD);
        mon_en = 1'b0;
        check("sync_left", exp_q.size(), 0);
        global_rst = 1'b1;
        tick();
        global_rst = 1'b0;
        n = 0;
        check("mid_rst_sd", SD, 0);
        check("mid_rst_sector", grid_sector, 1);
        check("mid_rst_judge", grid_judge, 0);
        check("mid_rst_state", o_dbg_state, ST_OFF);
        run_to(100);
        check("rerun_sync", pwm_sync, 1);
        check("rerun_sector", grid_sector, 4);
        run_to(105);
        check("rerun_sd", SD, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
